// File: rtl/balanced_line_tx.sv
// rtl/balanced_line_tx.sv - Manchester-coded frame transmitter with guaranteed idle gap
module balanced_line_tx #(
  parameter int DATA_W      = 8,
  parameter int HALF_PERIOD = 4,
  parameter int IDLE_GAP    = 20
) (
  input  logic              clk,
  input  logic              globalReset,
  input  logic [DATA_W-1:0] txData,
  input  logic              txValid,
  output logic              txReady,
  output logic              balancedCLK,
  output logic              busy,
  output logic              frameDone
);

  localparam int HALF_W = $clog2(HALF_PERIOD + 1);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam int GAP_W  = $clog2(IDLE_GAP + 1);

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_PERIOD - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(IDLE_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic                phase_q, phase_d;   // 0: first half of bit, 1: second half
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                line_q, line_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // State and output registers; reset discards any partial frame without a gap.
  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      half_q  <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
      line_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      line_q  <= line_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; line_d is the level the line will carry in the following cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    half_d  = half_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    line_d  = line_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        line_d = 1'b0;
        if (txValid && ready_q) begin
          shift_d = txData;
          half_d  = '0;
          bit_d   = '0;
          phase_d = 1'b0;
          line_d  = 1'b1;          // start bit first half
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end

      ST_START, ST_DATA: begin
        if (half_q != HALF_LAST) begin
          half_d = half_q + 1'b1;
        end else begin
          half_d = '0;
          if (!phase_q) begin
            // Mid-bit: second half carries the complement.
            phase_d = 1'b1;
            line_d  = ~line_q;
          end else begin
            phase_d = 1'b0;
            if (state_q == ST_START) begin
              state_d = ST_DATA;
              line_d  = shift_q[DATA_W-1];
            end else if (bit_q == BIT_LAST) begin
              state_d = ST_GAP;
              line_d  = 1'b0;
              gap_d   = '0;
              done_d  = 1'b1;
            end else begin
              bit_d   = bit_q + 1'b1;
              shift_d = shift_q << 1;
              line_d  = shift_d[DATA_W-1];
            end
          end
        end
      end

      ST_GAP: begin
        line_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        line_d  = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign txReady     = ready_q;
  assign balancedCLK = line_q;
  assign busy        = busy_q;
  assign frameDone   = done_q;

endmodule

// File: tb/tb_balanced_line_tx.sv
// tb/tb_balanced_line_tx.sv - scoreboard bench for balanced_line_tx
module tb_balanced_line_tx;

  localparam int W = 8;
  localparam int H = 4;
  localparam int G = 20;

  logic         clk;
  logic         globalReset;
  logic [W-1:0] txData;
  logic         txValid;
  logic         txReady;
  logic         balancedCLK;
  logic         busy;
  logic         frameDone;

  balanced_line_tx #(.DATA_W(W), .HALF_PERIOD(H), .IDLE_GAP(G)) dut (
    .clk         (clk),
    .globalReset (globalReset),
    .txData      (txData),
    .txValid     (txValid),
    .txReady     (txReady),
    .balancedCLK (balancedCLK),
    .busy        (busy),
    .frameDone   (frameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic line;
    logic ready;
    logic busy;
    logic done;
    logic in_bits;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic ready_prev = 1'b1;
  logic line_prev  = 1'b0;
  int   run_len    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected outputs for cycles 1..2H(W+1)+G after a handshake.
  task automatic push_frame(input logic [W-1:0] d);
    exp_t e;
    logic b;
    for (int k = 0; k <= W; k++) begin
      b = (k == 0) ? 1'b1 : d[W-k];
      for (int c = 0; c < 2*H; c++) begin
        e.line = (c < H) ? b : ~b;
        e.ready = 1'b0; e.busy = 1'b1; e.done = 1'b0; e.in_bits = 1'b1;
        q.push_back(e);
      end
    end
    for (int g = 0; g < G; g++) begin
      e.line = 1'b0; e.ready = 1'b0; e.busy = 1'b1; e.done = (g == 0); e.in_bits = 1'b0;
      q.push_back(e);
    end
  endtask

  // Model: push on predicted handshake, compare one expected entry per cycle.
  always @(posedge clk) begin
    exp_t e;
    if (globalReset) begin
      q.delete();
      ready_prev = 1'b1;
    end else if (ready_prev && txValid) begin
      push_frame(txData);
    end
    #1;
    if (q.size() > 0) e = q.pop_front();
    else begin
      e.line = 1'b0; e.ready = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.in_bits = 1'b0;
    end
    check("line",      balancedCLK, e.line);
    check("txReady",   txReady,     e.ready);
    check("busy",      busy,        e.busy);
    check("frameDone", frameDone,   e.done);
    if (e.in_bits) begin
      run_len = (balancedCLK == line_prev) ? run_len + 1 : 1;
      check("static_run_le_2H", (run_len <= 2*H), 1);
    end else begin
      run_len = 0;
    end
    line_prev  = balancedCLK;
    ready_prev = e.ready;
  end

  task automatic send_one(input logic [W-1:0] d);
    @(negedge clk);
    txData  = d;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
  endtask

  initial begin
    globalReset = 1'b1;
    txValid     = 1'b0;
    txData      = '0;
    repeat (3) @(negedge clk);
    globalReset = 1'b0;

    // Idle after reset.
    repeat (50) @(negedge clk);

    // Single 0xA5 frame.
    send_one(8'hA5);
    repeat (100) @(negedge clk);

    // 0x00 then 0xFF back to back with txValid held high.
    txData  = 8'h00;
    txValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    txData = 8'hFF;
    repeat (93) @(posedge clk);
    @(negedge clk);
    txValid = 1'b0;
    repeat (100) @(negedge clk);

    // Disturbance at cycle 30 must be ignored.
    txData  = 8'hA5;
    txValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    txValid = 1'b0;
    repeat (28) @(posedge clk);
    @(negedge clk);
    txData  = 8'h3C;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
    repeat (100) @(negedge clk);

    // Asynchronous reset at cycle 20 of a frame.
    txData  = 8'hC3;
    txValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    txValid = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    globalReset = 1'b1;
    #1;
    check("async_rst_line",  balancedCLK, 1'b0);
    check("async_rst_ready", txReady,     1'b1);
    check("async_rst_busy",  busy,        1'b0);
    check("async_rst_done",  frameDone,   1'b0);
    txData  = 8'h5A;
    txValid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    globalReset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    txValid = 1'b0;
    repeat (100) @(negedge clk);

    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
